goldschmidt_ctrl: RTL

Sequencing FSM for the Goldschmidt divider datapath. Drives load_regN, load_regD, sel_ND_mux and sel_K_mux to run the fixed schedule: initial IA·D, IA·N, then K·D, K·N pairs. Exposes a start/ready/done handshake to the issuing unit. Runtime iteration count is latched at start and clamped to MAX_ITER. It is a pure control block with no operand storage; N, D and IA go straight to the datapath.

---
 rtl/goldschmidt_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/goldschmidt_ctrl.sv
// Sequencing FSM for the Goldschmidt divider datapath: runs INIT_D, INIT_N and then
// n_eff ITER_D/ITER_N pairs, with a start/ready/done handshake toward the issuing unit.
module goldschmidt_ctrl #(
  parameter int MAX_ITER = 4,
  parameter int ITER_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iter,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              load_regN,
  output logic              load_regD,
  output logic [1:0]        sel_ND_mux,
  output logic              sel_K_mux,
  output logic [ITER_W-1:0] iter_idx
);

  localparam logic [ITER_W-1:0] MAX_ITER_V = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT_D = 3'd1,
    S_INIT_N = 3'd2,
    S_ITER_D = 3'd3,
    S_ITER_N = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e            state, state_nx;
  logic [ITER_W-1:0] iter_cnt, iter_cnt_nx;
  logic [ITER_W-1:0] n_eff, n_eff_nx;
  logic [ITER_W-1:0] n_clamped;

  assign n_clamped = (num_iter > MAX_ITER_V) ? MAX_ITER_V : num_iter;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      n_eff    <= '0;
    end else begin
      state    <= state_nx;
      iter_cnt <= iter_cnt_nx;
      n_eff    <= n_eff_nx;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx    = state;
    iter_cnt_nx = iter_cnt;
    n_eff_nx    = n_eff;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          n_eff_nx    = n_clamped;
          iter_cnt_nx = '0;
          state_nx    = S_INIT_D;
        end
      end
      S_INIT_D: state_nx = S_INIT_N;
      S_INIT_N: begin
        if (n_eff != '0) begin
          state_nx    = S_ITER_D;
          iter_cnt_nx = ITER_W'(1);
        end else begin
          state_nx    = S_DONE;
        end
      end
      S_ITER_D: state_nx = S_ITER_N;
      S_ITER_N: begin
        if (iter_cnt == n_eff) begin
          state_nx    = S_DONE;
          iter_cnt_nx = '0;
        end else begin
          state_nx    = S_ITER_D;
          iter_cnt_nx = iter_cnt + ITER_W'(1);
        end
      end
      S_DONE: begin
        state_nx    = S_IDLE;
        iter_cnt_nx = '0;
      end
      default: begin
        // Unused encodings fall back to a clean idle.
        state_nx    = S_IDLE;
        iter_cnt_nx = '0;
        n_eff_nx    = '0;
      end
    endcase
  end

  // Moore decode: outputs depend on the state register only.
  always_comb begin
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load_regN  = 1'b0;
    load_regD  = 1'b0;
    sel_ND_mux = 2'b00;
    sel_K_mux  = 1'b1;
    iter_idx   = '0;
    unique case (state)
      S_IDLE:   ready = 1'b1;
      S_INIT_D: begin
        busy      = 1'b1;
        load_regD = 1'b1;
      end
      S_INIT_N: begin
        busy       = 1'b1;
        load_regN  = 1'b1;
        sel_ND_mux = 2'b01;
      end
      S_ITER_D: begin
        busy       = 1'b1;
        load_regD  = 1'b1;
        sel_ND_mux = 2'b10;
        sel_K_mux  = 1'b0;
        iter_idx   = iter_cnt;
      end
      S_ITER_N: begin
        busy       = 1'b1;
        load_regN  = 1'b1;
        sel_ND_mux = 2'b11;
        sel_K_mux  = 1'b0;
        iter_idx   = iter_cnt;
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

endmodule
